// File: rtl/apb_cmd_master_if.sv
// Command / APB / response bundle for apb_cmd_master.
// The master modport is the command-to-APB bridge; slave is the environment
// around it (command source, APB slave and response sink).
interface apb_cmd_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    // command stream
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    // APB bus
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;
    // response stream
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  pready, prdata, pslverr,
        input  rsp_ready,
        output cmd_ready,
        output psel, penable, pwrite, paddr, pwdata,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output pready, prdata, pslverr,
        output rsp_ready,
        input  cmd_ready,
        input  psel, penable, pwrite, paddr, pwdata,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout
    );
endinterface

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: turns a valid/ready command stream into APB SETUP/ACCESS
// transfers and returns read data / error status on a response handshake.
// A wait-state watchdog aborts an ACCESS phase that never sees pready.
module apb_cmd_master #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16   // 0 disables the watchdog
) (
    input  logic                 clk,
    input  logic                 rst,
    apb_cmd_master_if.master     bus
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t              state_q;
    logic                psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic                rsp_timeout_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                cmd_fire;
    logic [CNT_W-1:0]    cnt_d;
    logic                timeout_hit;

    // Accept only from IDLE with no unconsumed response; held low in reset.
    assign bus.cmd_ready = !rst && (state_q == IDLE) && !rsp_valid_q;
    assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;

    // Wait-state counter next value; saturates so it can never wrap even
    // with the watchdog disabled.
    always_comb begin
        cnt_d       = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        timeout_hit = TO_EN && (cnt_d == TO_VAL);
    end

    // Transfer FSM with registered bus and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            // Response consumed: drop valid, keep the fields as they were.
            if (rsp_valid_q && bus.rsp_ready)
                rsp_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (cmd_fire) begin
                        pwrite_q  <= bus.cmd_write;
                        paddr_q   <= bus.cmd_addr;
                        pwdata_q  <= bus.cmd_wdata;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= SETUP;
                    end
                end

                SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ACCESS;
                end

                ACCESS: begin
                    // pready takes priority over a watchdog expiring this cycle.
                    if (bus.pready) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        state_q       <= IDLE;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= bus.pslverr;
                        rsp_timeout_q <= 1'b0;
                        rsp_rdata_q   <= (!pwrite_q && !bus.pslverr) ? bus.prdata : '0;
                    end else if (timeout_hit) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        state_q       <= IDLE;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_rdata_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master: directed cases then random traffic.
// Stimulus pushes the expected response at command accept; a monitor pops
// and compares on every response handshake; a behavioural APB slave serves
// each transfer with a planned number of wait states.
module tb_apb_cmd_master;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_cmd_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;   // ACCESS cycles with pready=0 before pready=1
        logic          err;
        logic [DW-1:0] rdata;
        int            acyc;    // cycle in which the command was accepted
    } plan_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          to;
        int            cyc;     // cycle in which rsp_valid must first appear
    } exp_t;

    plan_t plan_q[$];
    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    rr_mode = 1;        // 0: rsp_ready low, 1: high, 2: random
    int    last_hs = -100;
    int    last_acc = -100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: what a transfer must return, from the protocol rules.
    function automatic exp_t model(input plan_t p);
        exp_t e;
        if (TO != 0 && p.waits >= TO) begin
            e.rdata = '0; e.err = 1'b1; e.to = 1'b1;
            e.cyc   = p.acyc + 2 + TO;           // TO ACCESS cycles, then abort
        end else begin
            e.err   = p.err; e.to = 1'b0;
            e.rdata = (!p.wr && !p.err) ? p.rdata : '0;
            e.cyc   = p.acyc + 3 + p.waits;
        end
        return e;
    endfunction

    task automatic send(input plan_t p);
        int n;
        n = 0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = p.wr;
        bus.cmd_addr  = p.addr;
        bus.cmd_wdata = p.wdata;
        forever begin
            @(negedge clk);
            if (bus.cmd_ready) break;
            n++;
            if (n > 300) begin
                fail_now("accept_wait_expired");
                bus.cmd_valid = 1'b0;
                return;
            end
        end
        p.acyc   = cyc;
        last_acc = cyc;
        plan_q.push_back(p);
        exp_q.push_back(model(p));
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_wdata = $urandom;
        bus.cmd_addr  = AW'($urandom);
    endtask

    function automatic plan_t mk(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                 input int w, input logic e, input logic [DW-1:0] rd);
        plan_t p;
        p.wr = wr; p.addr = a; p.wdata = wd; p.waits = w; p.err = e; p.rdata = rd; p.acyc = 0;
        return p;
    endfunction

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 || plan_q.size() != 0 || bus.rsp_valid || bus.psel) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                fail_now("drain_wait_expired");
                return;
            end
        end
    endtask

    task automatic wait_sig(input int which, input string name);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if ((which == 0 && bus.rsp_valid) || (which == 1 && bus.penable)) break;
            n++;
            if (n > 100) begin
                fail_now(name);
                return;
            end
        end
    endtask

    // Response-ready driver.
    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.rsp_ready = (rr_mode == 0) ? 1'b0 : (rr_mode == 1) ? 1'b1 : 1'($urandom);
        end
    end

    // Behavioural APB slave: serves the planned transfer, checks bus stability.
    initial begin
        plan_t cur;
        int    acc;
        bit    act;
        acc = 0; act = 0;
        bus.pready = 1'b0; bus.prdata = '0; bus.pslverr = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                act = 0;
                bus.pready = 1'b0;
            end else if (bus.psel && !bus.penable) begin
                if (plan_q.size() == 0) begin
                    fail_now("setup_without_command");
                    act = 0;
                end else begin
                    cur = plan_q.pop_front();
                    act = 1; acc = 0;
                    chk("setup_cycle", 64'(cyc), 64'(cur.acyc + 1));
                    chk("setup_paddr", 64'(bus.paddr), 64'(cur.addr));
                    chk("setup_pwrite", 64'(bus.pwrite), 64'(cur.wr));
                    chk("setup_pwdata", 64'(bus.pwdata), 64'(cur.wdata));
                end
                bus.pready = 1'($urandom); bus.prdata = $urandom; bus.pslverr = 1'($urandom);
            end else if (bus.psel && bus.penable && act) begin
                chk("access_paddr", 64'(bus.paddr), 64'(cur.addr));
                chk("access_pwrite", 64'(bus.pwrite), 64'(cur.wr));
                chk("access_pwdata", 64'(bus.pwdata), 64'(cur.wdata));
                if (acc >= TO || acc > cur.waits) begin
                    fail_now("access_too_long");
                    act = 0;
                end
                if (acc == cur.waits) begin
                    bus.pready = 1'b1; bus.prdata = cur.rdata; bus.pslverr = cur.err;
                end else begin
                    bus.pready = 1'b0; bus.prdata = $urandom; bus.pslverr = 1'($urandom);
                end
                acc++;
            end else begin
                if (bus.penable && !bus.psel) fail_now("penable_without_psel");
                bus.pready = 1'($urandom); bus.prdata = $urandom; bus.pslverr = 1'($urandom);
            end
        end
    end

    // Response monitor / scoreboard.
    initial begin
        bit            pv;
        exp_t          e;
        logic [DW-1:0] s_rd;
        logic          s_err, s_to;
        pv = 0; s_rd = '0; s_err = 1'b0; s_to = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 0;
            end else begin
                if (bus.psel) chk("cmd_ready_while_busy", 64'(bus.cmd_ready), 64'(0));
                if (bus.rsp_valid) begin
                    chk("cmd_ready_while_rsp", 64'(bus.cmd_ready), 64'(0));
                    if (!pv) begin
                        if (exp_q.size() == 0) fail_now("unexpected_rsp_valid");
                        else chk("rsp_latency", 64'(cyc), 64'(exp_q[0].cyc));
                    end else begin
                        chk("hold_rdata", 64'(bus.rsp_rdata), 64'(s_rd));
                        chk("hold_err", 64'(bus.rsp_err), 64'(s_err));
                        chk("hold_timeout", 64'(bus.rsp_timeout), 64'(s_to));
                    end
                    s_rd = bus.rsp_rdata; s_err = bus.rsp_err; s_to = bus.rsp_timeout;
                    if (bus.rsp_ready) begin
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
                            chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                            chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(e.to));
                        end
                        last_hs = cyc;
                        pv = 0;
                    end else begin
                        pv = 1;
                    end
                end else begin
                    pv = 0;
                end
            end
        end
    end

    // Global guard against a hang.
    initial begin
        #2000000;
        $display("FAIL global_time_limit (cycle %0d)", cyc);
        $fatal(1, "time limit");
    end

    // Main sequence.
    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        #1;
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
        chk("rst_psel", 64'(bus.psel), 64'(0));
        chk("rst_penable", 64'(bus.penable), 64'(0));
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rst_paddr", 64'(bus.paddr), 64'(0));
        chk("rst_pwdata", 64'(bus.pwdata), 64'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", 64'(bus.cmd_ready), 64'(1));

        // Directed: zero-wait write, 3-wait read, slave error, timeout,
        // pready on the last allowed cycle.
        send(mk(1'b1, 8'h12, 32'hDEADBEEF, 0, 1'b0, 32'h0));
        drain();
        send(mk(1'b0, 8'h34, 32'h0, 3, 1'b0, 32'hCAFEF00D));
        drain();
        send(mk(1'b0, 8'h56, 32'h0, 0, 1'b1, 32'h12345678));
        drain();
        send(mk(1'b0, 8'h78, 32'h0, 10, 1'b0, 32'h55AA55AA));
        drain();
        send(mk(1'b1, 8'h9A, 32'h0BADCAFE, TO - 1, 1'b0, 32'h0));
        drain();
        // Previous transfer's bus values persist after completion.
        chk("hold_paddr_idle", 64'(bus.paddr), 64'(8'h9A));
        chk("hold_pwdata_idle", 64'(bus.pwdata), 64'(32'h0BADCAFE));

        // Response backpressure with a second command waiting.
        rr_mode = 0;
        send(mk(1'b0, 8'hA1, 32'h0, 0, 1'b0, 32'h11112222));
        fork
            send(mk(1'b1, 8'hA2, 32'h33334444, 1, 1'b0, 32'h0));
            begin
                wait_sig(0, "bp_rsp_valid_wait");
                repeat (5) @(posedge clk);
                rr_mode = 1;
            end
        join
        chk("bp_accept_cycle", 64'(last_acc), 64'(last_hs + 1));
        drain();

        // Async reset mid-ACCESS, then with a response pending.
        for (int v = 0; v < 2; v++) begin
            rr_mode = (v == 0) ? 1 : 0;
            send(mk(1'b0, 8'hC0, 32'h0, (v == 0) ? 10 : 0, 1'b0, 32'h77777777));
            wait_sig((v == 0) ? 1 : 0, "rst_phase_wait");
            @(posedge clk); #3;
            rst = 1'b1;
            exp_q.delete();
            plan_q.delete();
            #1;
            chk("arst_psel", 64'(bus.psel), 64'(0));
            chk("arst_penable", 64'(bus.penable), 64'(0));
            chk("arst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
            chk("arst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
            rr_mode = 1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            chk("arst_idle_ready", 64'(bus.cmd_ready), 64'(1));
            repeat (10) @(negedge clk);
            chk("arst_no_rsp", 64'(bus.rsp_valid), 64'(0));
        end

        // Random traffic with random response backpressure.
        rr_mode = 2;
        for (int i = 0; i < 60; i++) begin
            send(mk(1'($urandom), AW'($urandom), $urandom, $urandom_range(0, TO + 2),
                    ($urandom_range(0, 3) == 0), $urandom));
        end
        rr_mode = 1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
